async_flit_receiver: RTL and testbench
======================================

Name: async_flit_receiver

Overview:
- Clocked endpoint that terminates the router's 2-phase bundled-data link (req toggle / ack toggle) on the FPGA side.
- Synchronises the incoming request phase and captures the bundled flit, including its tail flag.
- Buffers the flit in a small FIFO and returns an ack toggle once the flit is stored.
- Presents flits to synchronous logic on a valid/ready stream and tracks packet boundaries and completed-packet count.

Parameters:
- DATA_WIDTH, 32, flit payload width.
- FIFO_DEPTH, 4, receive buffer entries; power of two, >= 2.
- SYNC_STAGES, 2, flops in the req_i synchroniser; >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_i  input  1  2-phase request from the upstream router; asynchronous to clk; every transition is one flit.
- data_i  input  DATA_WIDTH  bundled flit payload; stable from before the req_i transition until the matching ack_o transition.
- tail_i  input  1  bundled flag marking the last flit of a packet; same timing as data_i.
- ack_o  output  1  2-phase acknowledge; toggles once per captured flit.
- flit_data_o  output  DATA_WIDTH  FIFO head payload.
- flit_tail_o  output  1  FIFO head tail flag.
- flit_valid_o  output  1  FIFO non-empty.
- flit_ready_i  input  1  consumer accepts the head when high with flit_valid_o.
- packet_active_o  output  1  a packet has started capture and its tail is not yet captured.
- packet_count_o  output  16  completed packets captured; wraps.

Behaviour:
- Reset values: ack_o=0, all synchroniser stages 0, FIFO empty, flit_valid_o=0, flit_data_o=0, flit_tail_o=0, packet_active_o=0, packet_count_o=0.
- Reset is honoured in any state and discards FIFO contents and any pending flit. The upstream link is reset in the same domain event.
- After reset release, a synchronised req of 1 is a phase mismatch. It is treated as a pending flit.
- Synchroniser: req_i passes through SYNC_STAGES flops, giving req_s. No other logic samples req_i.
- Pending condition: pending = (req_s != ack_o).
- Capture: on an edge where pending=1 and the FIFO is not full (registered count < FIFO_DEPTH), {tail_i, data_i} is written to the FIFO tail and ack_o toggles on that same edge.
  - data_i and tail_i are sampled directly. The synchroniser delay provides bundling margin.
- Latency with SYNC_STAGES=2:
  - req_i toggles before edge E0. E0 loads stage 1, E1 loads req_s, E2 captures and toggles ack_o.
  - flit_valid_o is high from E2 if the FIFO was empty.
- At most one capture per req transition. After ack_o toggles, pending stays 0 until the next req_i transition propagates. Maximum rate is one flit per SYNC_STAGES+1 cycles.
- Full: pending is held and ack_o does not toggle. Capture occurs on the first edge after the count drops below FIFO_DEPTH.
- Pop: on an edge with flit_valid_o & flit_ready_i, the head is removed.
  - flit_data_o / flit_tail_o show the new head combinationally from storage.
  - When the FIFO is empty, flit_data_o / flit_tail_o hold their last value and are don't-care.
- Simultaneous push and pop:
  - Not full: both occur and the count is unchanged.
  - Full: the full check uses the pre-edge count, so only the pop occurs. The push happens on the next edge.
- Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- Packet FSM, two states, transitions on capture only:
  - IDLE: a capture with tail_i=0 moves to IN_PKT.
  - IDLE: a capture with tail_i=1 (single-flit packet) stays in IDLE and increments packet_count_o.
  - IN_PKT: a capture with tail_i=1 moves to IDLE and increments packet_count_o.
  - IN_PKT: a capture with tail_i=0 stays in IN_PKT.
  - packet_active_o = (state == IN_PKT).
- packet_count_o wraps 0xFFFF -> 0x0000 without a flag.

Test Plan:
- Single-flit packet: reset, then data_i=0xA5A5_0001, tail_i=1, req_i 0->1 → ack_o 0->1 exactly 3 edges after the toggle; flit_valid_o=1, flit_data_o=0xA5A5_0001, flit_tail_o=1; packet_count_o=1; packet_active_o never asserted.
- Three-flit packet, payloads 0x10, 0x11, 0x12 (tail on 0x12), 2-phase req toggles each gated on ack, flit_ready_i=1 → ack_o ends at 1 after 3 toggles; packet_active_o rises on the 0x10 capture and falls on the 0x12 capture; consumer sees 0x10, 0x11, 0x12 in order; packet_count_o=1.
- Backpressure, flit_ready_i=0, five flits sent → four captured, flit_valid_o=1, ack_o holds after the 4th toggle; one pop → 5th flit captured and ack_o toggles on the following edge; FIFO holds flits 2–5 in order.
- Full FIFO with flit_ready_i=1 and pending=1 on the same edge → pop only on that edge, push one edge later; count goes 4→3→4; no flit lost or duplicated.
- Reset mid-packet, after the 2nd of 4 flits with 2 flits queued → ack_o=0, flit_valid_o=0, packet_active_o=0, packet_count_o=0; a fresh single-flit packet afterwards is received correctly.
- Counter wrap: 65536 single-flit packets → packet_count_o returns to 0x0000; every ack_o toggle matches exactly one req_i toggle.

Source files
------------

// File: rtl/async_flit_receiver.sv
// ---------------------------------------------------------------------------
// async_flit_receiver
//
// Clocked endpoint for a 2-phase bundled-data link (req toggle / ack toggle).
// Each req_i transition carries one flit ({tail_i, data_i}).
//
// Flow:
//   - The request phase is synchronised.
//   - The bundled flit is captured into a small FIFO, and ack_o toggles.
//   - Flits are presented on a valid/ready stream.
//   - Packet boundaries are tracked, and completed packets are counted.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   req_i            2-phase request, asynchronous to clk
//   data_i, tail_i   bundled flit payload and tail flag
//   ack_o            2-phase acknowledge, one toggle per captured flit
//   flit_data_o      FIFO head payload
//   flit_tail_o      FIFO head tail flag
//   flit_valid_o     FIFO non-empty
//   flit_ready_i     consumer accepts the head
//   packet_active_o  a packet is open (started, tail not yet captured)
//   packet_count_o   completed packets captured, wraps at 16 bits
// ---------------------------------------------------------------------------
module async_flit_receiver #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  tail_i,
   output logic                  ack_o,
   output logic [DATA_WIDTH-1:0] flit_data_o,
   output logic                  flit_tail_o,
   output logic                  flit_valid_o,
   input  logic                  flit_ready_i,
   output logic                  packet_active_o,
   output logic [15:0]           packet_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] req_sync;
   logic                   req_s;
   logic                   pending;
   logic                   full;
   logic                   push;
   logic                   pop;

   logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
   logic [DATA_WIDTH:0]    head_hold;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [CNT_W-1:0]       count;

   state_t                 state;
   logic [15:0]            pkt_cnt;

   // ---- stage: req_i synchroniser (the only consumer of req_i) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         req_sync <= '0;
      end else begin
         req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
      end
   end

   assign req_s = req_sync[SYNC_STAGES-1];

   // ---- stage: capture / handshake ----
   // A phase difference between req_s and ack_o means one flit is waiting.
   // The full check uses the pre-edge count. A pop on a full edge therefore
   // delays the push by one cycle.
   assign pending = req_s ^ ack_o;
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign push    = pending & ~full;
   assign pop     = flit_valid_o & flit_ready_i;

   // Payload storage carries no reset. Only the occupancy tracking does.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {tail_i, data_i};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_o     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         head_hold <= '0;
      end else begin
         if (push) begin
            ack_o  <= ~ack_o;
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            // Keep the outgoing head so the outputs hold it once empty.
            head_hold <= mem[rd_ptr];
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // ---- stage: output stream ----
   assign flit_valid_o = (count != '0);
   assign {flit_tail_o, flit_data_o} = flit_valid_o ? mem[rd_ptr] : head_hold;

   // ---- stage: packet tracking (advances on capture only) ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pkt_cnt <= '0;
      end else if (push) begin
         case (state)
            IDLE: begin
               if (tail_i) begin
                  pkt_cnt <= pkt_cnt + 16'd1;
               end else begin
                  state <= IN_PKT;
               end
            end
            IN_PKT: begin
               if (tail_i) begin
                  state   <= IDLE;
                  pkt_cnt <= pkt_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign packet_active_o = (state == IN_PKT);
   assign packet_count_o  = pkt_cnt;

endmodule

// File: tb/tb_async_flit_receiver.sv
// ---------------------------------------------------------------------------
// tb_async_flit_receiver
//
// Scoreboard bench for async_flit_receiver.
//   - The upstream driver pushes every issued flit into a queue.
//   - A monitor pops and compares each flit that the consumer accepts.
//   - Packet state, packet count and ack parity are predicted from the
//     sequence of captured flits.
// ---------------------------------------------------------------------------
module tb_async_flit_receiver;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_i;
   logic [DW-1:0] data_i;
   logic          tail_i;
   logic          ack_o;
   logic [DW-1:0] flit_data_o;
   logic          flit_tail_o;
   logic          flit_valid_o;
   logic          flit_ready_i;
   logic          packet_active_o;
   logic [15:0]   packet_count_o;

   async_flit_receiver #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4),
      .SYNC_STAGES(2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_i          (req_i),
      .data_i         (data_i),
      .tail_i         (tail_i),
      .ack_o          (ack_o),
      .flit_data_o    (flit_data_o),
      .flit_tail_o    (flit_tail_o),
      .flit_valid_o   (flit_valid_o),
      .flit_ready_i   (flit_ready_i),
      .packet_active_o(packet_active_o),
      .packet_count_o (packet_count_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] sb[$];
   bit          rand_mode = 1'b0;

   // Reference packet model: is a packet open, and how many have completed.
   bit          model_open;
   logic [15:0] model_pkts;
   int          model_caps;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Consumer-side monitor: an accept happens on the next edge.
   always @(negedge clk) begin
      if (!reset && flit_valid_o && flit_ready_i) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit: got %0h expected none", {flit_tail_o, flit_data_o});
         end else begin
            check("flit_out", 64'({flit_tail_o, flit_data_o}), 64'(sb.pop_front()));
         end
      end
   end

   // Random consumer readiness during the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_mode) flit_ready_i = 1'($urandom_range(0, 1));
      end
   end

   task automatic model_clear();
      model_open = 1'b0;
      model_pkts = 16'd0;
      model_caps = 0;
      sb.delete();
   endtask

   task automatic note_capture(input logic t);
      model_caps++;
      if (t) begin
         model_open = 1'b0;
         model_pkts = model_pkts + 16'd1;
      end else begin
         model_open = 1'b1;
      end
      check("ack_parity", 64'(ack_o), 64'(model_caps % 2));
      check("packet_active", 64'(packet_active_o), 64'(model_open));
      check("packet_count", 64'(packet_count_o), 64'(model_pkts));
   endtask

   // Called at posedge+1; the new req phase reaches stage 1 at the next edge.
   task automatic issue(input logic [DW-1:0] d, input logic t);
      data_i = d;
      tail_i = t;
      sb.push_back({t, d});
      req_i = ~req_i;
   endtask

   task automatic wait_ack(input logic t, input int max, output int edges);
      logic prev;
      prev  = ack_o;
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (ack_o == prev && edges < max);
      if (ack_o == prev) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no toggle after %0d edges expected toggle", edges);
      end else begin
         note_capture(t);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic t, output int edges);
      issue(d, t);
      wait_ack(t, 300, edges);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_i = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic drain(input bit force_ready);
      int n;
      n = 0;
      if (force_ready) flit_ready_i = 1'b1;
      while ((sb.size() != 0 || flit_valid_o) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_queue_empty", 64'(sb.size()), 64'(0));
      check("drain_valid_low", 64'(flit_valid_o), 64'(0));
   endtask

   initial begin
      int lat;
      reset        = 1'b1;
      req_i        = 1'b0;
      data_i       = '0;
      tail_i       = 1'b0;
      flit_ready_i = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 64'(ack_o), 64'(0));
      check("rst_valid", 64'(flit_valid_o), 64'(0));
      check("rst_data", 64'(flit_data_o), 64'(0));
      check("rst_tail", 64'(flit_tail_o), 64'(0));
      check("rst_active", 64'(packet_active_o), 64'(0));
      check("rst_count", 64'(packet_count_o), 64'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single-flit packet.
      send(32'hA5A5_0001, 1'b1, lat);
      check("single_latency", 64'(lat), 64'(3));
      check("single_valid", 64'(flit_valid_o), 64'(1));
      check("single_data", 64'(flit_data_o), 64'hA5A5_0001);
      check("single_tail", 64'(flit_tail_o), 64'(1));
      drain(1'b1);

      // Three-flit packet with a ready consumer.
      do_reset();
      flit_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(32'h10 + 32'(i), (i == 2), lat);
         check("pkt3_latency", 64'(lat), 64'(3));
      end
      check("pkt3_ack_final", 64'(ack_o), 64'(1));
      drain(1'b1);

      // Backpressure: four captured, fifth held until one pop.
      do_reset();
      flit_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) send(32'h100 + 32'(i), 1'b0, lat);
      issue(32'h105, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check("full_ack_held", 64'(ack_o), 64'(0));
      check("full_valid", 64'(flit_valid_o), 64'(1));
      flit_ready_i = 1'b1;
      @(posedge clk);
      #1;
      flit_ready_i = 1'b0;
      check("full_pop_only_edge", 64'(ack_o), 64'(0));
      @(posedge clk);
      #1;
      check("full_push_next_edge", 64'(ack_o), 64'(1));
      if (ack_o) note_capture(1'b1);
      drain(1'b1);

      // Reset in the middle of a packet with two flits queued.
      do_reset();
      flit_ready_i = 1'b0;
      send(32'h20, 1'b0, lat);
      send(32'h21, 1'b0, lat);
      reset = 1'b1;
      req_i = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_ack", 64'(ack_o), 64'(0));
      check("midrst_valid", 64'(flit_valid_o), 64'(0));
      check("midrst_active", 64'(packet_active_o), 64'(0));
      check("midrst_count", 64'(packet_count_o), 64'(0));
      reset = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      send(32'h0BAD_F00D, 1'b1, lat);
      check("postrst_latency", 64'(lat), 64'(3));
      check("postrst_data", 64'(flit_data_o), 64'h0BAD_F00D);
      drain(1'b1);

      // Randomized traffic with a randomly stalling consumer.
      do_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send($urandom, ($urandom_range(0, 3) == 0), lat);
      end
      drain(1'b0);
      rand_mode    = 1'b0;
      flit_ready_i = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
